// File: rtl/team_08_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : team_08_button_conditioner
// Brief    : Synchronizes, debounces and edge-detects push buttons, and turns
//            the jump button's press into a sticky, acknowledged request.
// Revision : 1.0 - initial release
// ============================================================================
module team_08_button_conditioner #(
  parameter int NUM_BTN   = 3,
  parameter int DB_CYCLES = 10000,
  parameter int JUMP_IDX  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               jump_req,
  input  logic               jump_ack,
  output logic               jump_overrun
);

  localparam int              c_cnt_w   = $clog2(DB_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DB_CYCLES - 1);

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic               w_jump_press;

  // Plain two-flop synchronizer; nothing may sit between the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_level;
      logic               r_press;
      logic               r_release;

      // A single cycle of agreement restarts the count; the pulses are set
      // on the same edge that flips the level.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          if (r_sync2[i] == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt     <= '0;
            r_level   <= r_sync2[i];
            r_press   <= r_sync2[i];
            r_release <= ~r_sync2[i];
          end
        end
      end

      assign btn_level[i]   = r_level;
      assign btn_press[i]   = r_press;
      assign btn_release[i] = r_release;
    end
  endgenerate

  assign w_jump_press = btn_press[JUMP_IDX];

  // A press always (re)arms the request; an ack only clears when no press
  // coincides with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      jump_req     <= 1'b0;
      jump_overrun <= 1'b0;
    end else if (w_jump_press) begin
      jump_req <= 1'b1;
      if (jump_req && !jump_ack) begin
        jump_overrun <= 1'b1;
      end
    end else if (jump_ack) begin
      jump_req <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_team_08_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_team_08_button_conditioner
// Brief    : Scoreboard bench: reference model predicts outputs per edge,
//            monitor compares them one time unit after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_team_08_button_conditioner;

  localparam int NUM_BTN   = 3;
  localparam int DB_CYCLES = 4;
  localparam int JUMP_IDX  = 1;
  localparam int OUT_W     = 3 * NUM_BTN + 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               jump_req;
  logic               jump_ack;
  logic               jump_overrun;

  team_08_button_conditioner #(
    .NUM_BTN  (NUM_BTN),
    .DB_CYCLES(DB_CYCLES),
    .JUMP_IDX (JUMP_IDX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .jump_req    (jump_req),
    .jump_ack    (jump_ack),
    .jump_overrun(jump_overrun)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int cycle  = 0;
  bit done   = 1'b0;

  logic [OUT_W-1:0] exp_q[$];

  // Reference model state: expected outputs, a two-deep delay line of raw
  // samples, a history of the synchronized samples, and per-channel ages.
  logic [NUM_BTN-1:0] m_level, m_press, m_rel;
  logic               m_req, m_ovr;
  logic [NUM_BTN-1:0] dly[$];
  logic [NUM_BTN-1:0] s2_hist[$];
  int                 age[NUM_BTN];

  task automatic model_edge();
    logic [NUM_BTN-1:0] s2, np, nr;
    logic               p;
    bit                 all_diff;
    if (reset) begin
      m_level = '0; m_press = '0; m_rel = '0; m_req = 1'b0; m_ovr = 1'b0;
      dly.delete(); dly.push_back('0); dly.push_back('0);
      s2_hist.delete();
      for (int c = 0; c < NUM_BTN; c++) age[c] = 0;
    end else begin
      p  = m_press[JUMP_IDX];
      s2 = dly.pop_front();
      dly.push_back(btn_raw);
      s2_hist.push_back(s2);
      if (s2_hist.size() > DB_CYCLES) void'(s2_hist.pop_front());
      np = '0; nr = '0;
      for (int c = 0; c < NUM_BTN; c++) begin
        age[c]++;
        // Accept a new level once DB_CYCLES consecutive samples disagree.
        if (age[c] >= DB_CYCLES) begin
          all_diff = 1'b1;
          for (int j = 0; j < DB_CYCLES; j++)
            if (s2_hist[s2_hist.size()-1-j][c] == m_level[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) np[c] = 1'b1; else nr[c] = 1'b1;
            age[c] = 0;
          end
        end
      end
      m_press = np;
      m_rel   = nr;
      if (p) begin
        if (m_req && !jump_ack) m_ovr = 1'b1;
        m_req = 1'b1;
      end else if (jump_ack) begin
        m_req = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!done) begin
      model_edge();
      exp_q.push_back({m_level, m_press, m_rel, m_req, m_ovr});
    end
  end

  always @(posedge clk) begin
    logic [OUT_W-1:0] exp_v, got_v;
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {btn_level, btn_press, btn_release, jump_req, jump_overrun};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL outputs cycle %0d: got lvl=%b prs=%b rel=%b req=%b ovr=%b, expected lvl=%b prs=%b rel=%b req=%b ovr=%b",
                 cycle, got_v[OUT_W-1 -: NUM_BTN], got_v[2*NUM_BTN+1 -: NUM_BTN],
                 got_v[NUM_BTN+1 -: NUM_BTN], got_v[1], got_v[0],
                 exp_v[OUT_W-1 -: NUM_BTN], exp_v[2*NUM_BTN+1 -: NUM_BTN],
                 exp_v[NUM_BTN+1 -: NUM_BTN], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v, input int n);
    btn_raw[idx] = v;
    cyc(n);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
  endtask

  int run[NUM_BTN];
  int press_cnt;
  logic [8:0] bounce;

  initial begin
    reset = 1'b1; btn_raw = '0; jump_ack = 1'b0;
    // Held buttons through reset are re-detected as fresh presses.
    btn_raw = 3'b111;
    cyc(3);
    reset = 1'b0;
    cyc(10);
    btn_raw = '0;
    cyc(10);

    // Glitch of DB_CYCLES-1, then exact DB_CYCLES, then a long hold.
    set_btn(0, 1'b1, 3);  set_btn(0, 1'b0, 10);
    set_btn(0, 1'b1, 4);  set_btn(0, 1'b0, 12);
    set_btn(0, 1'b1, 10); set_btn(0, 1'b0, 10);

    // Bounce on channel 2 must yield exactly one press and one release.
    bounce = 9'b111101101;
    press_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      btn_raw[2] = bounce[i];
      cyc(1);
      if (btn_press[2]) press_cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (btn_press[2]) press_cnt++;
    end
    tests++;
    if (press_cnt != 1) begin
      fails++;
      $display("FAIL bounce_press_count: got %0d, expected 1", press_cnt);
    end
    set_btn(2, 1'b0, 10);

    // Jump handshake: press, hold without ack, one-cycle ack, stray ack.
    set_btn(1, 1'b1, 10);
    jump_ack = 1'b1; cyc(1); jump_ack = 1'b0;
    cyc(3);
    jump_ack = 1'b1; cyc(2); jump_ack = 1'b0;
    set_btn(1, 1'b0, 10);

    // Overrun: second press while the request is still pending.
    set_btn(1, 1'b1, 10); set_btn(1, 1'b0, 10);
    set_btn(1, 1'b1, 10); set_btn(1, 1'b0, 10);
    jump_ack = 1'b1; cyc(3); jump_ack = 1'b0;
    cyc(3);

    // Press coinciding with ack while a request is pending.
    do_reset(2);
    set_btn(1, 1'b1, 10); set_btn(1, 1'b0, 10);
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      jump_ack = btn_press[1];
    end
    jump_ack = 1'b0;
    set_btn(1, 1'b0, 10);

    // Reset in the middle of a debounce count.
    set_btn(1, 1'b1, 5);
    do_reset(2);
    cyc(12);
    set_btn(1, 1'b0, 10);

    // Randomized runs of varying length, random acks, occasional resets.
    for (int c = 0; c < NUM_BTN; c++) run[c] = $urandom_range(1, 8);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_BTN; c++) begin
        if (run[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          run[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(4, 14) : $urandom_range(1, 5);
        end
        run[c]--;
      end
      jump_ack = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0; jump_ack = 1'b0;
    cyc(3);
    done = 1'b1;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
